// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_X0  = 5'd0;

  // Forwarding select for one ALU source. M is checked first so the youngest
  // producer wins when M and W both hold the same destination register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic [4:0] rdw,
    input logic       regwritem,
    input logic       regwritew
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if ((rs != REG_X0) && (rs == rdm) && regwritem) begin
      sel = FWD_MEM;
    end else if ((rs != REG_X0) && (rs == rdw) && regwritew) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: load-use and memory-wait stalls, branch flushes, operand
// forwarding from a private E/M/W register-address pipeline, plus a sticky
// memory timeout flag and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rdd,
  input  logic             resultsrce0,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             pcsrce,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             stallf,
  output logic             stalld,
  output logic             stallemw,
  output logic             flushd,
  output logic             flushe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [4:0] rs1e_q, rs1e_d;
  logic [4:0] rs2e_q, rs2e_d;
  logic [4:0] rde_q,  rde_d;
  logic [4:0] rdm_q,  rdm_d;
  logic [4:0] rdw_q,  rdw_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic              memstall;
  logic              lwstall;
  logic [WAIT_W-1:0] wait_cnt;

  // Hazard detection is masked during reset so every output reads idle.
  always_comb begin
    memstall = dmem_req_m & ~dmem_ready & ~reset;
    lwstall  = resultsrce0 & (rde_q != REG_X0) &
               ((rde_q == rs1d) | (rde_q == rs2d)) & ~reset;
  end

  // Stall/flush outputs; an outstanding memory access freezes everything,
  // so it also suppresses flushes that would otherwise drop live state.
  always_comb begin
    stallf   = lwstall | memstall;
    stalld   = lwstall | memstall;
    stallemw = memstall;
    flushd   = pcsrce & ~memstall;
    flushe   = (lwstall | pcsrce) & ~memstall;
  end

  // Operand forwarding from the shadow M/W destinations.
  always_comb begin
    forwardae = fwd_sel(rs1e_q, rdm_q, rdw_q, regwritem, regwritew);
    forwardbe = fwd_sel(rs2e_q, rdm_q, rdw_q, regwritem, regwritew);
  end

  // Shadow pipeline next state: hold on memory wait, bubble E on flush.
  always_comb begin
    rs1e_d = rs1e_q;
    rs2e_d = rs2e_q;
    rde_d  = rde_q;
    rdm_d  = rdm_q;
    rdw_d  = rdw_q;
    if (!memstall) begin
      if (flushe) begin
        rs1e_d = REG_X0;
        rs2e_d = REG_X0;
        rde_d  = REG_X0;
      end else begin
        rs1e_d = rs1d;
        rs2e_d = rs2d;
        rde_d  = rdd;
      end
      rdm_d = rde_q;
      rdw_d = rdm_q;
    end
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1e_q <= REG_X0;
      rs2e_q <= REG_X0;
      rde_q  <= REG_X0;
      rdm_q  <= REG_X0;
      rdw_q  <= REG_X0;
    end else begin
      rs1e_q <= rs1e_d;
      rs2e_q <= rs2e_d;
      rde_q  <= rde_d;
      rdm_q  <= rdm_d;
      rdw_q  <= rdw_d;
    end
  end

  // Timeout sets on the edge that completes the MEM_TIMEOUT-th waiting cycle.
  always_comb begin
    mem_timeout_d = mem_timeout_q;
    if (memstall && (wait_cnt >= WAIT_LAST)) begin
      mem_timeout_d = 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout_q <= 1'b0;
    end else begin
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  hz_sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (memstall),
    .clr   (~memstall),
    .count (wait_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallf),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushd),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 64;

  logic             clk;
  logic             reset;
  logic [4:0]       rs1d, rs2d, rdd;
  logic             resultsrce0, regwritem, regwritew, pcsrce;
  logic             dmem_req_m, dmem_ready;
  logic [1:0]       forwardae, forwardbe;
  logic             stallf, stalld, stallemw, flushd, flushe, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks;
  int errors;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1d        (rs1d),
    .rs2d        (rs2d),
    .rdd         (rdd),
    .resultsrce0 (resultsrce0),
    .regwritem   (regwritem),
    .regwritew   (regwritew),
    .pcsrce      (pcsrce),
    .dmem_req_m  (dmem_req_m),
    .dmem_ready  (dmem_ready),
    .forwardae   (forwardae),
    .forwardbe   (forwardbe),
    .stallf      (stallf),
    .stalld      (stalld),
    .stallemw    (stallemw),
    .flushd      (flushd),
    .flushe      (flushe),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fwdA[1:0], fwdB[1:0], stallf, stalld, stallemw, flushd, flushe, mem_timeout}
  function automatic logic [9:0] ctl();
    return {forwardae, forwardbe, stallf, stalld, stallemw, flushd, flushe, mem_timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    rs1d = a;
    rs2d = b;
    rdd  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    set_d(5'd0, 5'd0, 5'd0);
    resultsrce0 = 1'b0; regwritem = 1'b0; regwritew = 1'b0; pcsrce = 1'b0;
    dmem_req_m = 1'b1; dmem_ready = 1'b0;

    // 1: reset with a pending memory wait
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ctl", 32'(ctl()), 32'h0);
    end
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    reset = 1'b0;
    dmem_req_m = 1'b0;
    #1;
    chk("post_rst_ctl", 32'(ctl()), 32'h0);
    step();
    chk("post_rst_ctl2", 32'(ctl()), 32'h0);
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", flush_cnt, 32'd0);

    // 2: forwarding priority M over W
    set_d(5'd5, 5'd5, 5'd5);
    step(); step(); step();
    regwritem = 1'b1; regwritew = 1'b1;
    #1;
    chk("fwd_mem", 32'(ctl()), 32'(10'b10_10_000000));
    regwritem = 1'b0;
    #1;
    chk("fwd_wb", 32'(ctl()), 32'(10'b01_01_000000));
    regwritew = 1'b0;
    #1;
    chk("fwd_none", 32'(ctl()), 32'h0);

    // 3: load-use stall
    set_d(5'd0, 5'd0, 5'd7);
    step();
    resultsrce0 = 1'b1;
    set_d(5'd1, 5'd7, 5'd0);
    #1;
    chk("lwstall", 32'(ctl()), 32'(10'b00_00_110010));
    step();
    chk("lw_bubble", 32'(ctl()), 32'h0);
    chk("lw_stall_cnt", stall_cnt, 32'd1);

    // 4: branch taken together with load-use
    resultsrce0 = 1'b0;
    set_d(5'd0, 5'd0, 5'd9);
    step();
    resultsrce0 = 1'b1;
    pcsrce = 1'b1;
    set_d(5'd9, 5'd0, 5'd0);
    #1;
    chk("br_lw", 32'(ctl()), 32'(10'b00_00_110110));
    chk("br_flush_cnt0", flush_cnt, 32'd0);
    step();
    chk("br_flush_cnt1", flush_cnt, 32'd1);
    chk("br_stall_cnt", stall_cnt, 32'd2);

    // 5: memory wait dominates the branch flush
    resultsrce0 = 1'b0;
    pcsrce = 1'b0;
    set_d(5'd3, 5'd4, 5'd3);
    step(); step();
    regwritem = 1'b1;
    #1;
    chk("mw_fwd_setup", 32'(ctl()), 32'(10'b10_00_000000));
    set_d(5'd0, 5'd0, 5'd0);
    pcsrce = 1'b1;
    dmem_req_m = 1'b1;
    dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mw_hold", 32'(ctl()), 32'(10'b10_00_111000));
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready", 32'(ctl()), 32'(10'b10_00_000110));
    chk("mw_stall_cnt", stall_cnt, 32'd5);
    step();
    chk("mw_advance", 32'(ctl()), 32'(10'b00_00_000110));
    chk("mw_flush_cnt", flush_cnt, 32'd2);
    pcsrce = 1'b0;
    dmem_req_m = 1'b0;
    regwritem = 1'b0;

    // 6: memory timeout, sticky until reset
    dmem_req_m = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    chk("to_before", 32'(mem_timeout), 32'd0);
    step();
    chk("to_rise", 32'(mem_timeout), 32'd1);
    dmem_ready = 1'b1;
    dmem_req_m = 1'b0;
    step();
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'(5 + MEM_TIMEOUT));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    chk("to_cnt_cleared", stall_cnt, 32'd0);
    regwritem = 1'b1;
    regwritew = 1'b1;
    #1;
    chk("x0_no_fwd", 32'(ctl()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
